// File: rtl/hazard_ctrl.sv
// hazard_ctrl
//   Hazard/flush controller for a classic 5-stage pipeline.
//   - Detects load-use hazards between the EX and ID instructions and holds
//     PC and IF/ID while bubbles are injected into ID/EX.
//   - Kills wrong-path instructions for FLUSH_CYCLES cycles after an EX
//     redirect (taken branch / jump).
//   - Selects EX-result forwarding for rs1/rs2 when no stall is needed.
//   - Keeps saturating stall and flush event counters.
// Ports
//   clk, rst                        clock (rising edge), async active-high reset
//   id_reg{1,2}_raddr/_ren          source operands of the ID instruction
//   ex_reg_wen/_waddr, ex_is_load   destination info of the EX instruction
//   ex_redirect                     EX resolved a taken branch/jump this cycle
//   pc_stall, if_id_stall           hold PC / IF/ID
//   if_id_flush, pipeline_flush     bubble into IF/ID / ID/EX
//   forward_to_alu                  {rs2 from EX, rs1 from EX}
//   stall_cnt, flush_cnt            saturating event counters
module hazard_ctrl #(
  parameter int REG_ADDR_WIDTH  = 5,
  parameter int FLUSH_CYCLES    = 2,
  parameter int LOAD_USE_CYCLES = 1,
  parameter int CNT_WIDTH       = 16
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [REG_ADDR_WIDTH-1:0] id_reg1_raddr,
  input  logic [REG_ADDR_WIDTH-1:0] id_reg2_raddr,
  input  logic                      id_reg1_ren,
  input  logic                      id_reg2_ren,
  input  logic                      ex_reg_wen,
  input  logic [REG_ADDR_WIDTH-1:0] ex_reg_waddr,
  input  logic                      ex_is_load,
  input  logic                      ex_redirect,
  output logic                      pc_stall,
  output logic                      if_id_stall,
  output logic                      if_id_flush,
  output logic                      pipeline_flush,
  output logic [1:0]                forward_to_alu,
  output logic [CNT_WIDTH-1:0]      stall_cnt,
  output logic [CNT_WIDTH-1:0]      flush_cnt
);

  // The down-counter only ever holds (cycles-1), so $clog2(max) bits suffice.
  localparam int MAXC = (FLUSH_CYCLES > LOAD_USE_CYCLES) ? FLUSH_CYCLES : LOAD_USE_CYCLES;
  localparam int CW   = (MAXC > 1) ? $clog2(MAXC) : 1;
  localparam logic [CW-1:0] FL_RELOAD = CW'(FLUSH_CYCLES - 1);
  localparam logic [CW-1:0] LU_RELOAD = CW'(LOAD_USE_CYCLES - 1);

  typedef enum logic [1:0] {RUN, LD_STALL, FLUSH} state_e;

  state_e                 state_q, state_d;
  logic [CW-1:0]          cnt_q, cnt_d;
  logic [CNT_WIDTH-1:0]   stall_cnt_q, flush_cnt_q;
  logic                   hit1, hit2, lu;

  assign hit1 = id_reg1_ren & ex_reg_wen & (ex_reg_waddr != '0) & (ex_reg_waddr == id_reg1_raddr);
  assign hit2 = id_reg2_ren & ex_reg_wen & (ex_reg_waddr != '0) & (ex_reg_waddr == id_reg2_raddr);
  assign lu   = ex_is_load & (hit1 | hit2);

  always_comb begin
    state_d        = state_q;
    cnt_d          = cnt_q;
    pc_stall       = 1'b0;
    if_id_stall    = 1'b0;
    if_id_flush    = 1'b0;
    pipeline_flush = 1'b0;

    // A redirect wins in every state; in FLUSH it restarts the kill window.
    if (ex_redirect) begin
      if_id_flush    = 1'b1;
      pipeline_flush = 1'b1;
      if (FLUSH_CYCLES > 1) begin
        state_d = FLUSH;
        cnt_d   = FL_RELOAD;
      end else begin
        state_d = RUN;
        cnt_d   = '0;
      end
    end else begin
      case (state_q)
        RUN: begin
          if (lu) begin
            pc_stall       = 1'b1;
            if_id_stall    = 1'b1;
            pipeline_flush = 1'b1;
            if (LOAD_USE_CYCLES > 1) begin
              state_d = LD_STALL;
              cnt_d   = LU_RELOAD;
            end
          end
        end
        LD_STALL: begin
          pc_stall       = 1'b1;
          if_id_stall    = 1'b1;
          pipeline_flush = 1'b1;
          if (cnt_q <= CW'(1)) begin
            state_d = RUN;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q - CW'(1);
          end
        end
        FLUSH: begin
          // ID holds a wrong-path instruction, so its load-use is ignored.
          if_id_flush    = 1'b1;
          pipeline_flush = 1'b1;
          if (cnt_q <= CW'(1)) begin
            state_d = RUN;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q - CW'(1);
          end
        end
        default: begin
          state_d = RUN;
          cnt_d   = '0;
        end
      endcase
    end

    // Reset forces bubbles so unreset pipeline registers never carry junk.
    if (rst) begin
      pc_stall       = 1'b0;
      if_id_stall    = 1'b0;
      if_id_flush    = 1'b1;
      pipeline_flush = 1'b1;
    end

    forward_to_alu = pipeline_flush ? 2'b00 : {hit2 & ~ex_is_load, hit1 & ~ex_is_load};
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= RUN;
      cnt_q       <= '0;
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      if (pc_stall && (stall_cnt_q != '1))
        stall_cnt_q <= stall_cnt_q + CNT_WIDTH'(1);
      if (if_id_flush && (flush_cnt_q != '1))
        flush_cnt_q <= flush_cnt_q + CNT_WIDTH'(1);
    end
  end

  assign stall_cnt = stall_cnt_q;
  assign flush_cnt = flush_cnt_q;

endmodule

// File: tb/tb_hazard_ctrl.sv
// Directed testbench for hazard_ctrl. Two instances share the stimulus:
// dut (FLUSH=2, LOAD_USE=1, CNT_WIDTH=16) and dut3 (FLUSH=2, LOAD_USE=3, CNT_WIDTH=4).
module tb_hazard_ctrl;
  logic       clk = 1'b0;
  logic       rst;
  logic [4:0] r1, r2, wa;
  logic       ren1, ren2, wen, ld, redir;

  logic        ps, ids, idf, pf;
  logic [1:0]  fwd;
  logic [15:0] scnt, fcnt;
  logic        ps3, ids3, idf3, pf3;
  logic [1:0]  fwd3;
  logic [3:0]  scnt3, fcnt3;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  hazard_ctrl #(.REG_ADDR_WIDTH(5), .FLUSH_CYCLES(2), .LOAD_USE_CYCLES(1), .CNT_WIDTH(16)) dut (
    .clk(clk), .rst(rst),
    .id_reg1_raddr(r1), .id_reg2_raddr(r2), .id_reg1_ren(ren1), .id_reg2_ren(ren2),
    .ex_reg_wen(wen), .ex_reg_waddr(wa), .ex_is_load(ld), .ex_redirect(redir),
    .pc_stall(ps), .if_id_stall(ids), .if_id_flush(idf), .pipeline_flush(pf),
    .forward_to_alu(fwd), .stall_cnt(scnt), .flush_cnt(fcnt)
  );

  hazard_ctrl #(.REG_ADDR_WIDTH(5), .FLUSH_CYCLES(2), .LOAD_USE_CYCLES(3), .CNT_WIDTH(4)) dut3 (
    .clk(clk), .rst(rst),
    .id_reg1_raddr(r1), .id_reg2_raddr(r2), .id_reg1_ren(ren1), .id_reg2_ren(ren2),
    .ex_reg_wen(wen), .ex_reg_waddr(wa), .ex_is_load(ld), .ex_redirect(redir),
    .pc_stall(ps3), .if_id_stall(ids3), .if_id_flush(idf3), .pipeline_flush(pf3),
    .forward_to_alu(fwd3), .stall_cnt(scnt3), .flush_cnt(fcnt3)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic idle();
    r1 = '0; r2 = '0; wa = '0; ren1 = 0; ren2 = 0; wen = 0; ld = 0; redir = 0;
  endtask

  // EX load of x5, ID reads x5 as rs1
  task automatic ld_use();
    idle(); wen = 1; ld = 1; wa = 5'd5; r1 = 5'd5; ren1 = 1;
  endtask

  // {pc_stall, if_id_stall, if_id_flush, pipeline_flush, fwd[1:0]}
  function automatic logic [31:0] ctl();
    return 32'({ps, ids, idf, pf, fwd});
  endfunction
  function automatic logic [31:0] ctl3();
    return 32'({ps3, ids3, idf3, pf3, fwd3});
  endfunction

  task automatic do_reset();
    @(negedge clk); rst = 1; idle();
    @(negedge clk); rst = 0;
  endtask

  initial begin
    // reset state, with a hazard on the inputs that must be masked
    rst = 1; ld_use();
    #1;
    chk("rst_ctl",  ctl(),  32'b001100);
    chk("rst_cnt",  32'({scnt, fcnt}), 32'd0);
    @(negedge clk); rst = 0; idle();

    // 1: load-use, one bubble
    @(negedge clk); ld_use(); #1;
    chk("lu_ctl",   ctl(), 32'b110100);
    @(negedge clk); idle(); #1;
    chk("lu_after", ctl(), 32'b000000);
    chk("lu_scnt",  32'(scnt), 32'd1);

    // load to x0 never stalls
    @(negedge clk); ld_use(); wa = 5'd0; r1 = 5'd0; #1;
    chk("x0_load",  ctl(), 32'b000000);

    // 2: ALU forward on rs2, then x0 destination
    @(negedge clk); idle(); wen = 1; wa = 5'd7; r2 = 5'd7; ren2 = 1; r1 = 5'd7; #1;
    chk("fwd_rs2",  ctl(), 32'b000010);
    ren1 = 1; #1;
    chk("fwd_both", ctl(), 32'b000011);
    ren1 = 0; wa = 5'd0; r2 = 5'd0; #1;
    chk("fwd_x0",   ctl(), 32'b000000);

    // 3: redirect pulse, two flush cycles
    do_reset();
    @(negedge clk); idle(); redir = 1; #1;
    chk("rd_c0",    ctl(), 32'b001100);
    @(negedge clk); idle(); #1;
    chk("rd_c1",    ctl(), 32'b001100);
    @(negedge clk); idle(); #1;
    chk("rd_c2",    ctl(), 32'b000000);
    chk("rd_fcnt",  32'(fcnt), 32'd2);
    chk("rd_scnt",  32'(scnt), 32'd0);

    // redirect restart inside FLUSH extends the window
    @(negedge clk); idle(); redir = 1; #1;
    @(negedge clk); idle(); redir = 1; #1;
    chk("rs_c1",    ctl(), 32'b001100);
    @(negedge clk); idle(); #1;
    chk("rs_c2",    ctl(), 32'b001100);
    @(negedge clk); idle(); #1;
    chk("rs_c3",    ctl(), 32'b000000);
    chk("rs_fcnt",  32'(fcnt), 32'd5);

    // 4: redirect together with load-use
    do_reset();
    @(negedge clk); ld_use(); redir = 1; #1;
    chk("rdlu_c0",  ctl(), 32'b001100);
    @(negedge clk); ld_use(); #1;
    chk("rdlu_c1",  ctl(), 32'b001100);
    @(negedge clk); idle(); #1;
    chk("rdlu_c2",  ctl(), 32'b000000);
    chk("rdlu_scnt", 32'(scnt), 32'd0);

    // 5: LOAD_USE=3, redirect on second stall cycle
    do_reset();
    @(negedge clk); ld_use(); #1;
    chk("l3_c0",    ctl3(), 32'b110100);
    @(negedge clk); ld_use(); redir = 1; #1;
    chk("l3_c1",    ctl3(), 32'b001100);
    @(negedge clk); ld_use(); #1;
    chk("l3_c2",    ctl3(), 32'b001100);
    @(negedge clk); idle(); #1;
    chk("l3_c3",    ctl3(), 32'b000000);
    chk("l3_scnt",  32'(scnt3), 32'd1);
    chk("l3_fcnt",  32'(fcnt3), 32'd2);

    // full three-cycle stall without redirect
    do_reset();
    @(negedge clk); ld_use(); #1;
    chk("l3f_c0",   ctl3(), 32'b110100);
    @(negedge clk); idle(); #1;
    chk("l3f_c1",   ctl3(), 32'b110100);
    @(negedge clk); idle(); #1;
    chk("l3f_c2",   ctl3(), 32'b110100);
    @(negedge clk); idle(); #1;
    chk("l3f_c3",   ctl3(), 32'b000000);
    chk("l3f_scnt", 32'(scnt3), 32'd3);

    // 6: reset pulse in the middle of FLUSH
    do_reset();
    @(negedge clk); idle(); redir = 1; #1;
    @(negedge clk); idle(); #1;
    chk("mr_pre",   32'(fcnt), 32'd1);
    ld_use(); rst = 1; #1;
    chk("mr_ctl",   ctl(), 32'b001100);
    chk("mr_cnt",   32'({scnt, fcnt}), 32'd0);
    @(negedge clk); rst = 0; idle(); #1;
    chk("mr_run",   ctl(), 32'b000000);

    // saturation: CNT_WIDTH=4, 20 consecutive stall cycles
    do_reset();
    for (int i = 0; i < 20; i++) begin
      @(negedge clk); ld_use(); #1;
      if (i == 15) chk("sat_15", 32'(scnt3), 32'd15);
    end
    @(negedge clk); idle(); #1;
    chk("sat_end",  32'(scnt3), 32'd15);
    chk("sat_wide", 32'(scnt), 32'd20);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
